// File: rtl/router_pkg.sv
// Shared definitions for the router output arbiter: FSM states, VC codes, defaults.
package router_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

    localparam logic VC1 = 1'b1;
    localparam logic VC2 = 1'b0;

    localparam int DEF_NUM_IN = 5;
    localparam int DEF_DATA_W = 64;

    // Pointer width that stays legal even for a single-input build.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first eligible index at or above start, wrapping to 0.
module rr_picker
    import router_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int PTR_W  = ptr_width(DEF_NUM_IN)
) (
    input  logic [NUM_IN-1:0] eligible,
    input  logic [PTR_W-1:0]  start,
    output logic [NUM_IN-1:0] winner_onehot,
    output logic [PTR_W-1:0]  winner_idx,
    output logic              any_valid
);

    int               pos;
    logic [PTR_W-1:0] idx;

    always_comb begin
        winner_onehot = '0;
        winner_idx    = '0;
        any_valid     = 1'b0;
        pos           = 0;
        idx           = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            pos = int'(start) + k;
            if (pos >= NUM_IN) begin
                pos = pos - NUM_IN;
            end
            idx = PTR_W'(pos);
            if (!any_valid && eligible[idx]) begin
                any_valid          = 1'b1;
                winner_onehot[idx] = 1'b1;
                winner_idx         = idx;
            end
        end
    end

endmodule

// File: rtl/router_output_arbiter.sv
// One router output port: per-VC round-robin arbitration with a single registered flit stage.
// Optional stall counter output enabled by defining ROUTER_ARB_STALL_CNT_EN.
module router_output_arbiter
    import router_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        req,
    input  logic [NUM_IN-1:0]        req_vc,
    input  logic [NUM_IN*DATA_W-1:0] data_in,
    input  logic                     polarity,
    input  logic                     ready,
    output logic [NUM_IN-1:0]        grant,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        data_out,
    output logic                     out_vc
`ifdef ROUTER_ARB_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int PTR_W = ptr_width(NUM_IN);

    arb_state_t        state_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic              out_vc_reg;
    logic [PTR_W-1:0]  rr_ptr_reg [2];

    logic [DATA_W-1:0] flit_arr [NUM_IN];
    logic [NUM_IN-1:0] eligible;
    logic [NUM_IN-1:0] win_onehot;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  ptr_next;
    logic              any_valid;
    logic              capture;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
            assign eligible[gi] = req[gi] & (req_vc[gi] == polarity);
            assign flit_arr[gi] = data_in[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_picker #(
        .NUM_IN (NUM_IN),
        .PTR_W  (PTR_W)
    ) u_rr_picker (
        .eligible      (eligible),
        .start         (rr_ptr_reg[polarity]),
        .winner_onehot (win_onehot),
        .winner_idx    (win_idx),
        .any_valid     (any_valid)
    );

    // A held flit blocks capture until it drains; reset masks the grant combinationally.
    assign capture   = reset & any_valid & ((state_reg == IDLE) | ready);
    assign grant     = capture ? win_onehot : '0;
    assign ptr_next  = (win_idx == PTR_W'(NUM_IN - 1)) ? '0 : win_idx + 1'b1;
    assign out_valid = (state_reg == SEND);
    assign data_out  = data_out_reg;
    assign out_vc    = out_vc_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            data_out_reg  <= '0;
            out_vc_reg    <= VC2;
            rr_ptr_reg[0] <= '0;
            rr_ptr_reg[1] <= '0;
        end else if (capture) begin
            data_out_reg         <= flit_arr[win_idx];
            out_vc_reg           <= req_vc[win_idx];
            rr_ptr_reg[polarity] <= ptr_next;
            state_reg            <= SEND;
        end else if ((state_reg == SEND) && ready) begin
            data_out_reg <= '0;
            out_vc_reg   <= VC2;
            state_reg    <= IDLE;
        end
    end

`ifdef ROUTER_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == SEND) && !ready && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter; expected flits queued at grant time, checked when presented.
module tb_router_output_arbiter;

    localparam int NUM_IN = 5;
    localparam int DATA_W = 64;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              vc;
    } exp_t;

    logic                     clk;
    logic                     reset;
    logic [NUM_IN-1:0]        req;
    logic [NUM_IN-1:0]        req_vc;
    logic [NUM_IN*DATA_W-1:0] data_in;
    logic                     polarity;
    logic                     ready;
    logic [NUM_IN-1:0]        grant;
    logic                     out_valid;
    logic [DATA_W-1:0]        data_out;
    logic                     out_vc;
`ifdef ROUTER_ARB_STALL_CNT_EN
    logic [15:0]              stall_cnt;
`endif

    logic [DATA_W-1:0] flit [NUM_IN];
    exp_t              sb [$];
    int                total;
    int                bad;
    int                seq;

    router_output_arbiter #(
        .NUM_IN (NUM_IN),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_vc    (req_vc),
        .data_in   (data_in),
        .polarity  (polarity),
        .ready     (ready),
        .grant     (grant),
        .out_valid (out_valid),
        .data_out  (data_out),
        .out_vc    (out_vc)
`ifdef ROUTER_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        data_in = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            data_in[i*DATA_W +: DATA_W] = flit[i];
        end
    end

    task automatic set_flits();
        seq++;
        for (int i = 0; i < NUM_IN; i++) begin
            flit[i] = {8'hA0 + 8'(i), 24'(seq), 32'hDEAD_0000 + 32'(i)};
        end
    endtask

    task automatic drive(input logic [NUM_IN-1:0] r, input logic [NUM_IN-1:0] rv,
                         input logic pol, input logic rdy);
        req      = r;
        req_vc   = rv;
        polarity = pol;
        ready    = rdy;
        set_flits();
    endtask

    // Called just after a rising edge; compares at the falling edge, returns just after the next rising edge.
    task automatic check(input string tag, input logic [NUM_IN-1:0] eg, input logic ev);
        exp_t e;
        int   gi_idx;
        @(negedge clk);
        total++;
        assert (grant === eg) else begin
            bad++;
            $error("FAIL %s grant: got %b want %b", tag, grant, eg);
        end
        total++;
        assert (out_valid === ev) else begin
            bad++;
            $error("FAIL %s out_valid: got %b want %b", tag, out_valid, ev);
        end
        if (ev) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL %s scoreboard empty: got data_out %h want none", tag, data_out);
            end else begin
                e = sb[0];
                total++;
                assert (data_out === e.data) else begin
                    bad++;
                    $error("FAIL %s data_out: got %h want %h", tag, data_out, e.data);
                end
                total++;
                assert (out_vc === e.vc) else begin
                    bad++;
                    $error("FAIL %s out_vc: got %b want %b", tag, out_vc, e.vc);
                end
                if (ready) void'(sb.pop_front());
            end
        end else begin
            total++;
            assert (data_out === '0) else begin
                bad++;
                $error("FAIL %s data_out idle: got %h want 0", tag, data_out);
            end
        end
        if (eg != '0) begin
            gi_idx = 0;
            for (int i = 0; i < NUM_IN; i++) if (eg[i]) gi_idx = i;
            sb.push_back('{data: flit[gi_idx], vc: req_vc[gi_idx]});
        end
        $display("step %-10s req=%b vc=%b pol=%b rdy=%b grant=%b valid=%b data_out=%h",
                 tag, req, req_vc, polarity, ready, grant, out_valid, data_out);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        seq      = 0;
        reset    = 1'b0;
        drive(5'b11111, 5'b11111, 1'b1, 1'b1);
        @(posedge clk);
        #1;

        // Held in reset with every input requesting: nothing granted or presented.
        check("rst_a", 5'b00000, 1'b0);
        check("rst_b", 5'b00000, 1'b0);
`ifdef ROUTER_ARB_STALL_CNT_EN
        total++;
        assert (stall_cnt === 16'd0) else begin
            bad++;
            $error("FAIL rst stall_cnt: got %0d want 0", stall_cnt);
        end
`endif
        reset = 1'b1;
        check("first", 5'b00001, 1'b0);

        // Sustained round-robin across all five VC1 requesters.
        for (int k = 1; k <= 5; k++) begin
            set_flits();
            check("rr", 5'(1 << (k % 5)), 1'b1);
        end
        drive(5'b00000, 5'b11111, 1'b1, 1'b1);
        check("drain1", 5'b00000, 1'b1);
        check("idle1", 5'b00000, 1'b0);

        // Independent per-VC pointers: VC1 pointer is 1, VC2 pointer is 0.
        drive(5'b01101, 5'b01001, 1'b1, 1'b1);
        check("vc1_a", 5'b01000, 1'b0);
        drive(5'b01101, 5'b01001, 1'b0, 1'b1);
        check("vc2_a", 5'b00100, 1'b1);
        drive(5'b01101, 5'b01001, 1'b1, 1'b1);
        check("vc1_wrap", 5'b00001, 1'b1);
        drive(5'b01101, 5'b01001, 1'b0, 1'b1);
        check("vc2_b", 5'b00100, 1'b1);
        drive(5'b00000, 5'b00000, 1'b1, 1'b1);
        check("drain2", 5'b00000, 1'b1);
        check("idle2", 5'b00000, 1'b0);

        // Backpressure: capture input 1, then four stalled cycles with data_in changing.
        drive(5'b00010, 5'b00010, 1'b1, 1'b0);
        check("stall_cap", 5'b00010, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(5'b10010, 5'b10010, (k % 2) == 0, 1'b0);
            check("stall", 5'b00000, 1'b1);
        end
`ifdef ROUTER_ARB_STALL_CNT_EN
        total++;
        assert (stall_cnt === 16'd4) else begin
            bad++;
            $error("FAIL stall_cnt: got %0d want 4", stall_cnt);
        end
`endif
        drive(5'b10010, 5'b10010, 1'b1, 1'b1);
        check("unstall", 5'b10000, 1'b1);
        drive(5'b00000, 5'b00000, 1'b1, 1'b1);
        check("drain3", 5'b00000, 1'b1);
        check("idle3", 5'b00000, 1'b0);

        // Reset during a stalled SEND discards the flit and both pointers.
        drive(5'b00100, 5'b00100, 1'b1, 1'b0);
        check("pre_rst", 5'b00100, 1'b0);
        drive(5'b00000, 5'b00000, 1'b1, 1'b0);
        check("held", 5'b00000, 1'b1);
        reset = 1'b0;
        #1;
        total++;
        assert (out_valid === 1'b0) else begin
            bad++;
            $error("FAIL async_rst out_valid: got %b want 0", out_valid);
        end
        total++;
        assert (data_out === '0) else begin
            bad++;
            $error("FAIL async_rst data_out: got %h want 0", data_out);
        end
`ifdef ROUTER_ARB_STALL_CNT_EN
        total++;
        assert (stall_cnt === 16'd0) else begin
            bad++;
            $error("FAIL async_rst stall_cnt: got %0d want 0", stall_cnt);
        end
`endif
        $display("step %-10s valid=%b data_out=%h", "async_rst", out_valid, data_out);
        sb.delete();
        drive(5'b11111, 5'b11111, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("post_vc1", 5'b00001, 1'b0);
        drive(5'b11111, 5'b00000, 1'b0, 1'b1);
        check("post_vc2", 5'b00001, 1'b1);
        drive(5'b00000, 5'b00000, 1'b1, 1'b1);
        check("drain4", 5'b00000, 1'b1);
        check("idle4", 5'b00000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_output_arbiter.md
ROUTER_OUTPUT_ARBITER -- requirements
Module: router_output_arbiter

Interface
REQ-001 Parameter NUM_IN, default 5, number of input channels (N, S, E, W, local PE) competing for one output port.
REQ-002 Parameter DATA_W, default 64, flit width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low clears all state immediately, release synchronous to clk.
REQ-005 req  input  NUM_IN  per-input request; bit i high = input i holds a flit for this port.
REQ-006 req_vc  input  NUM_IN  per-input virtual channel of the pending flit (1 = VC1, 0 = VC2).
REQ-007 data_in  input  NUM_IN*DATA_W  flattened flits; input i occupies bits [i*DATA_W +: DATA_W].
REQ-008 polarity  input  1  current VC phase; high = VC1 accepting, low = VC2 accepting.
REQ-009 ready  input  1  output channel can accept a flit this cycle (driven from the output channel's not-blocked).
REQ-010 grant  output  NUM_IN  one-hot acknowledge; bit i high one cycle = input i's flit captured.
REQ-011 out_valid  output  1  data_out holds a flit for the output channel.
REQ-012 data_out  output  DATA_W  registered granted flit; zero when out_valid low.
REQ-013 out_vc  output  1  VC of the flit in data_out.

Function
REQ-014 Input i is eligible when req[i]=1 and req_vc[i]=polarity.
REQ-015 FSM states: IDLE (no flit held), SEND (flit held, out_valid=1).
REQ-016 IDLE: if any eligible input, capture winner's data_in and req_vc into output registers, pulse grant[winner], go SEND next cycle; else stay IDLE, grant=0.
REQ-017 SEND with ready=1: flit transfers that cycle; if an input is eligible the same cycle, capture it and stay SEND (one flit per cycle sustained), else clear data_out to 0, go IDLE.
REQ-018 SEND with ready=0: hold data_out, out_vc stable; grant=0; no capture regardless of requests.
REQ-019 Winner selection: round-robin per VC; two pointers rr_ptr[VC1], rr_ptr[VC2], each of width clog2(NUM_IN).
REQ-020 Search starts at rr_ptr[polarity] and proceeds upward with wrap from NUM_IN-1 to 0; first eligible index wins.
REQ-021 On capture, rr_ptr[polarity] = (winner+1) mod NUM_IN; other pointer unchanged.
REQ-022 Grant-to-capture latency zero: grant[i] and data register load in the same cycle; data_out visible next cycle.
REQ-023 At most one grant bit high per cycle; grant never asserted in a cycle where capture does not occur.
REQ-024 Polarity change while in SEND does not alter held flit or out_vc.
REQ-025 req dropped before grant: input simply not eligible; no state effect.

Reset
REQ-026 Reset low: state=IDLE, grant=0, out_valid=0, data_out=0, out_vc=0, both rr_ptr=0.
REQ-027 Reset mid-SEND discards the held flit; no grant issued in the first cycle after release unless an input is eligible.

Configuration
REQ-028 Macro ROUTER_ARB_STALL_CNT_EN defined: add output stall_cnt (16 bits), incremented each cycle in SEND with ready=0, saturating at 0xFFFF, cleared by reset.
REQ-029 Macro undefined: no stall_cnt port or logic; all other behaviour identical.

Structure
REQ-030 Shared package router_pkg holds FSM state encoding (IDLE, SEND), VC encoding constants, default NUM_IN and DATA_W.
REQ-031 One sub-module rr_picker: combinational round-robin search (eligible vector, start pointer -> one-hot winner, index, any-valid), instantiated once.

Verification
REQ-032 Reset low with req=5'b11111 -> grant=0, out_valid=0, data_out=0; after release with polarity=1, req_vc=all 1 -> grant=5'b00001 first cycle.
REQ-033 All five inputs requesting VC1, polarity=1, ready=1 -> grants 0,1,2,3,4,0 on consecutive cycles, data_out follows one cycle later.
REQ-034 Input 2 req_vc=0, input 3 req_vc=1, polarity alternating from 1 -> grant input 3, then input 2; each pointer advances independently.
REQ-035 Flit captured, ready=0 for 4 cycles -> data_out stable, grant=0, out_valid=1; with macro, stall_cnt=4; ready=1 -> transfer, next eligible granted same cycle.
REQ-036 Reset asserted during SEND with ready=0 -> out_valid and data_out 0 immediately, rr_ptr back to 0.
